// File: rtl/uart_cmd_parser.sv
// Decodes SOF/ADDR/DATA/CHK command frames popped from a UART receive FIFO.
// Optional UART_CMD_ACK_EN: answer every frame with 06 (good) or 15 (bad) on the transmit FIFO.
module uart_cmd_parser #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 50000,
  parameter int         TO_BIT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       err_chk,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EMIT
`ifdef UART_CMD_ACK_EN
    , S_ACK
`endif
  } state_t;

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]        addr_q, addr_d, data_q, data_d;
  logic [7:0]        cmd_addr_q, cmd_addr_d, cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d, err_chk_q, err_chk_d;
  logic              waiting, to_hit, pop, frame_good;
`ifdef UART_CMD_ACK_EN
  logic              good_q, good_d;
`endif

  // Timeout has priority over a byte arriving on the same cycle, so that byte stays in the FIFO.
  assign waiting    = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign to_hit     = waiting && (to_cnt_q == TO_LAST);
  assign pop        = !reset && !rx_empty && !to_hit && (waiting || (state_q == S_IDLE));
  assign frame_good = (r_data == (SOF ^ addr_q ^ data_q));

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    err_chk_d   = 1'b0;
`ifdef UART_CMD_ACK_EN
    good_d      = good_q;
`endif
    if (waiting && rx_empty && !to_hit) begin
      to_cnt_d = to_cnt_q + TO_BIT'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (pop && (r_data == SOF)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (to_hit) begin
          state_d = S_IDLE;
        end else if (pop) begin
          addr_d  = r_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (to_hit) begin
          state_d = S_IDLE;
        end else if (pop) begin
          data_d  = r_data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (to_hit) begin
          state_d = S_IDLE;
        end else if (pop) begin
          state_d = S_EMIT;
`ifdef UART_CMD_ACK_EN
          good_d  = frame_good;
`endif
          if (frame_good) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_data_d  = data_q;
          end else begin
            err_chk_d = 1'b1;
          end
        end
      end
`ifdef UART_CMD_ACK_EN
      S_EMIT: state_d = S_ACK;
      S_ACK: begin
        if (!tx_full) state_d = S_IDLE;
      end
`else
      S_EMIT: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
`ifdef UART_CMD_ACK_EN
      good_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_chk_q   <= err_chk_d;
`ifdef UART_CMD_ACK_EN
      good_q      <= good_d;
`endif
    end
  end

  // Partial-frame fields need no reset: they are only observed after being refilled.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign rd_uart     = pop;
  assign err_timeout = to_hit;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign err_chk     = err_chk_q;

`ifdef UART_CMD_ACK_EN
  assign wr_uart = (state_q == S_ACK) && !tx_full;
  assign w_data  = (state_q == S_ACK) ? (good_q ? 8'h06 : 8'h15) : 8'h00;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign wr_uart        = 1'b0;
  assign w_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FIFO stand-in with per-byte gaps, frame-level reference parser.
module tb_uart_cmd_parser;

  localparam logic [7:0] SOF = 8'hA5;
  localparam int         TO  = 8;

  localparam logic [2:0] EV_GOOD = 3'd1;
  localparam logic [2:0] EV_BAD  = 3'd2;
  localparam logic [2:0] EV_TOUT = 3'd3;
  localparam logic [2:0] EV_ACK  = 3'd4;

  logic       clk, reset, rx_empty, tx_full;
  logic [7:0] r_data;
  logic       rd_uart, wr_uart, cmd_valid, err_chk, err_timeout;
  logic [7:0] w_data, cmd_addr, cmd_data;

  uart_cmd_parser #(.SOF(SOF), .TIMEOUT(TO), .TO_BIT(16)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .err_chk(err_chk), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  logic [7:0]  src_q[$];
  int          gap_q[$];
  int          gap_cnt = 0;
  logic [18:0] obs_q[$], exp_q[$];

  logic        prev_rd = 1'b0, last_wr = 1'b0, no_rd_win = 1'b0, rand_tx = 1'b0;
  int          since_pop = 1000;
  logic [7:0]  last_a = 8'h00, last_d = 8'h00, seen_a = 8'h00, seen_d = 8'h00;

  int          m_pos = 0;
  logic [7:0]  m_a = 8'h00, m_d = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame-level parser over the byte stream; a gap of TO-1 or more empty
  // cycles after a mid-frame pop abandons the frame before the byte is considered.
  task automatic model_feed(input logic [7:0] b, input int g);
    if (m_pos != 0 && g >= TO - 1) begin
      exp_q.push_back({EV_TOUT, 16'h0});
      m_pos = 0;
    end
    case (m_pos)
      0: if (b == SOF) m_pos = 1;
      1: begin m_a = b; m_pos = 2; end
      2: begin m_d = b; m_pos = 3; end
      default: begin
        if (b == (SOF ^ m_a ^ m_d)) exp_q.push_back({EV_GOOD, m_a, m_d});
        else                        exp_q.push_back({EV_BAD, 16'h0});
`ifdef UART_CMD_ACK_EN
        exp_q.push_back({EV_ACK, 8'h00, (b == (SOF ^ m_a ^ m_d)) ? 8'h06 : 8'h15});
`endif
        m_pos = 0;
      end
    endcase
  endtask

  task automatic model_end();
    if (m_pos != 0) exp_q.push_back({EV_TOUT, 16'h0});
    m_pos = 0;
  endtask

  task automatic refresh();
    rx_empty = (src_q.size() == 0) || (gap_cnt != 0);
    r_data   = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  // Gap g: number of empty cycles between the previous pop and this byte becoming visible.
  task automatic send(input logic [7:0] b, input int g);
    model_feed(b, g);
    if (src_q.size() == 0) gap_cnt = g;
    src_q.push_back(b);
    gap_q.push_back(g);
    refresh();
  endtask

  task automatic tick();
    logic       rd, cv, ec, et, wr, rst_seen;
    logic [7:0] ca, cd, wd;
    @(negedge clk);
    rd = rd_uart; cv = cmd_valid; ec = err_chk; et = err_timeout;
    wr = wr_uart; wd = w_data; ca = cmd_addr; cd = cmd_data;
    if (rd) check("rd_while_empty", {31'h0, rx_empty}, 32'h0);
    if (no_rd_win) check("rd_during_ack_wait", {31'h0, rd}, 32'h0);
`ifdef UART_CMD_ACK_EN
    if (wr) obs_q.push_back({EV_ACK, 8'h00, wd});
    if (tx_full) check("wr_while_full", {31'h0, wr}, 32'h0);
`else
    check("wr_tied_off", {23'h0, wr, wd}, 32'h0);
`endif
    if (cv) begin
      obs_q.push_back({EV_GOOD, ca, cd});
      check("cmd_valid_latency", {31'h0, prev_rd}, 32'h1);
      last_a = ca;
      last_d = cd;
    end else begin
      check("cmd_addr_hold", {24'h0, ca}, {24'h0, last_a});
      check("cmd_data_hold", {24'h0, cd}, {24'h0, last_d});
    end
    if (ec) begin
      obs_q.push_back({EV_BAD, 16'h0});
      check("err_chk_latency", {31'h0, prev_rd}, 32'h1);
    end
    if (et) begin
      obs_q.push_back({EV_TOUT, 16'h0});
      check("timeout_cycle", since_pop, TO - 1);
      check("pop_on_timeout", {31'h0, rd}, 32'h0);
    end
    last_wr = wr; seen_a = ca; seen_d = cd;
    prev_rd = rd;
    since_pop = rd ? 0 : since_pop + 1;
    @(posedge clk);
    rst_seen = reset;
    #1;
    if (rst_seen) begin
      last_a = 8'h00; last_d = 8'h00; prev_rd = 1'b0;
    end
    if (rd && src_q.size() != 0) begin
      void'(src_q.pop_front());
      void'(gap_q.pop_front());
      if (gap_q.size() != 0) gap_cnt = gap_q[0];
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
`ifndef UART_CMD_ACK_EN
    if (rand_tx) tx_full = 1'($urandom_range(0, 1));
`endif
    refresh();
  endtask

  task automatic run_bytes();
    int guard = 0;
    while (src_q.size() != 0) begin
      if (guard > 20000) begin
        check("fifo_stall", src_q.size(), 0);
        src_q.delete(); gap_q.delete(); gap_cnt = 0; refresh();
        break;
      end
      guard++;
      tick();
    end
  endtask

  task automatic run_all();
    run_bytes();
    repeat (TO + 4) tick();
    model_end();
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check(tag, {13'h0, obs_q[i]}, {13'h0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 2);
    if (r == 7) return TO - 2;
    if (r == 8) return TO - 1;
    return TO + 3;
  endfunction

  initial begin
    logic [7:0] a, d, c;
    int         kind;

    // Reset with a byte waiting: nothing may be popped and every output reads 0.
    reset = 1'b1; tx_full = 1'b0; rx_empty = 1'b0; r_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_uart", {31'h0, rd_uart}, 32'h0);
    check("rst_wr_uart", {31'h0, wr_uart}, 32'h0);
    check("rst_w_data", {24'h0, w_data}, 32'h0);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_cmd_addr", {24'h0, cmd_addr}, 32'h0);
    check("rst_cmd_data", {24'h0, cmd_data}, 32'h0);
    check("rst_err_chk", {31'h0, err_chk}, 32'h0);
    check("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    refresh();

    send(8'hA5, 0); send(8'h12, 0); send(8'h34, 0); send(8'h83, 0);
    run_all();
    compare("good_frame");

    send(8'hA5, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 0);
    run_all();
    compare("bad_chk");
    check("hold_addr_after_bad", {24'h0, seen_a}, 32'h12);
    check("hold_data_after_bad", {24'h0, seen_d}, 32'h34);

    send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0); send(8'h01, 0); send(8'h02, 0); send(8'hA6, 0);
    run_all();
    compare("hunt_sof");

    send(8'hA5, 0); send(8'h12, 0);
    run_all();
    send(8'hA5, 0); send(8'hA5, 1); send(8'h5A, 2); send(8'h5A, 0);
    run_all();
    compare("timeout_then_frame");

    // Reset after the DATA byte: the CHK byte that follows is just noise in IDLE.
    send(8'hA5, 0); send(8'h12, 0); send(8'h34, 0);
    run_bytes();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pos = 0;
    send(8'h83, 0); send(8'hA5, 0); send(8'h01, 0); send(8'h02, 0); send(8'hA6, 0);
    run_all();
    compare("reset_mid_frame");

`ifdef UART_CMD_ACK_EN
    tx_full = 1'b1;
    send(8'hA5, 0); send(8'h12, 0); send(8'h34, 0); send(8'h83, 0); send(8'h00, 0);
    repeat (5) tick();
    no_rd_win = 1'b1;
    repeat (20) tick();
    no_rd_win = 1'b0;
    tx_full = 1'b0;
    tick();
    check("ack_on_first_free", {31'h0, last_wr}, 32'h1);
    run_all();
    compare("ack_backpressure");
`endif

    rand_tx = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      a = 8'($urandom);
      d = 8'($urandom);
      c = SOF ^ a ^ d;
      if (kind == 2) c = c ^ (8'h01 << $urandom_range(0, 7));
      if (kind <= 2) begin
        send(SOF, rgap()); send(a, rgap()); send(d, rgap()); send(c, rgap());
      end else if (kind == 3) begin
        send(a, rgap());
      end else begin
        send(SOF, rgap()); send(a, rgap());
      end
    end
    run_all();
    rand_tx = 1'b0;
    tx_full = 1'b0;
    compare("random_stream");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
